// File: rtl/layer_scheduler.sv
// layer_scheduler: sequences the conv+pool layer pipeline for one inference.
// Each layer gets a one-cycle start pulse, then the scheduler waits for that
// layer's pool-done pulse. A per-layer watchdog catches layers that never
// finish, and a done pulse from any other layer is treated as a fault.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for run; stray layer_done pulses ignored
// ISSUE  | one cycle: start pulse to layer_idx, watchdog reloaded
// WAIT   | waiting for layer_done[layer_idx]; watchdog counting down
// DONE   | one cycle: all_done pulse, then back to IDLE
// ERR    | fault latched in err_code until clear_err or abort
module layer_scheduler #(
    parameter int NUM_LAYERS     = 2,
    parameter int IDX_W          = 3,
    parameter int TMO_W          = 20,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  abort,
    input  logic                  clear_err,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [NUM_LAYERS-1:0] layer_start,
    output logic [IDX_W-1:0]      layer_idx,
    output logic                  busy,
    output logic                  all_done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [CNT_W-1:0]      cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    // Watchdog is a down-counter: loaded with TIMEOUT_CYCLES-1 in ISSUE, so
    // reaching zero marks the TIMEOUT_CYCLES-th cycle spent in WAIT.
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_TMO  = 2'd1;
    localparam logic [1:0] ERR_SPUR = 2'd2;

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        idx_nxt;
    logic [TMO_W-1:0]        timer;
    logic [TMO_W-1:0]        timer_nxt;
    logic [1:0]              code_nxt;
    logic                    cnt_clr;
    logic [NUM_LAYERS-1:0]   cur_mask;
    logic                    cur_done;
    logic                    other_done;
    logic                    tmo_hit;
    logic                    busy_state;

    // One-hot mask of the active layer, and done-pulse classification against it
    always_comb begin
        cur_mask = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            cur_mask[i] = (layer_idx == IDX_W'(i));
        end
        cur_done   = |(layer_done & cur_mask);
        other_done = |(layer_done & ~cur_mask);
        tmo_hit    = (timer == '0);
        busy_state = (state == S_ISSUE) || (state == S_WAIT) || (state == S_DONE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-value decode for index, watchdog and error code
    always_comb begin
        state_nxt = state;
        idx_nxt   = layer_idx;
        timer_nxt = timer;
        code_nxt  = err_code;
        cnt_clr   = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nxt = S_ISSUE;
                    idx_nxt   = '0;
                    cnt_clr   = 1'b1;
                end
            end

            S_ISSUE: begin
                timer_nxt = TMO_LOAD;
                if (|layer_done) begin
                    state_nxt = S_ERR;
                    code_nxt  = ERR_SPUR;
                end else begin
                    state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (!tmo_hit) begin
                    timer_nxt = timer - TMO_W'(1);
                end
                // A foreign done is a fault even when the expected one also fires;
                // a genuine done beats a simultaneous watchdog expiry.
                if (other_done) begin
                    state_nxt = S_ERR;
                    code_nxt  = ERR_SPUR;
                end else if (cur_done) begin
                    if (layer_idx == LAST_IDX) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ISSUE;
                        idx_nxt   = layer_idx + IDX_W'(1);
                    end
                end else if (tmo_hit) begin
                    state_nxt = S_ERR;
                    code_nxt  = ERR_TMO;
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            S_ERR: begin
                if (clear_err) begin
                    state_nxt = S_IDLE;
                    code_nxt  = ERR_NONE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                code_nxt  = ERR_NONE;
            end
        endcase

        // Abort overrides everything, including a run request seen in IDLE.
        if (abort) begin
            state_nxt = S_IDLE;
            code_nxt  = ERR_NONE;
            idx_nxt   = layer_idx;
            cnt_clr   = 1'b0;
        end
    end

    // Datapath registers: layer index, watchdog, error code, run cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            layer_idx   <= '0;
            timer       <= '0;
            err_code    <= ERR_NONE;
            cycle_count <= '0;
        end else begin
            layer_idx <= idx_nxt;
            timer     <= timer_nxt;
            err_code  <= code_nxt;
            if (cnt_clr) begin
                cycle_count <= '0;
            end else if (busy_state && (cycle_count != '1)) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

    // Moore output decode from registered state
    always_comb begin
        layer_start = '0;
        if (state == S_ISSUE) begin
            layer_start = cur_mask;
        end
        busy     = busy_state;
        all_done = (state == S_DONE);
        error    = (state == S_ERR);
    end

endmodule

// File: doc/layer_scheduler.md
Name: layer_scheduler

Overview:
Sequences the CNN layer pipeline (conv+pool stages) for one inference.
- Issues a one-cycle start pulse to each layer in order and waits for that layer's pool-done pulse.
- Guards each layer with a timeout and flags spurious done pulses.
- Reports busy, completion, error and total run cycle count to the host/top level.

Parameters:
NUM_LAYERS, 2, number of sequenced layers (1..8)
IDX_W, 3, width of layer_idx; must satisfy 2^IDX_W >= NUM_LAYERS
TMO_W, 20, width of per-layer watchdog counter
TIMEOUT_CYCLES, 1000000, max WAIT cycles per layer; must be <= 2^TMO_W
CNT_W, 32, width of cycle_count

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
run  in  1  start request, sampled only in IDLE
abort  in  1  return to IDLE from any state, highest priority
clear_err  in  1  leave ERR state
layer_done  in  NUM_LAYERS  per-layer done pulses (bit i = layer i pool done)
layer_start  out  NUM_LAYERS  one-hot, one-cycle start pulse to layer i
layer_idx  out  IDX_W  index of the active layer
busy  out  1  high in ISSUE/WAIT/DONE
all_done  out  1  one-cycle pulse on successful completion
error  out  1  high while in ERR
err_code  out  2  0 none, 1 timeout, 2 spurious done
cycle_count  out  CNT_W  cycles spent busy in the last/current run

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; layer_idx=0; timer=0; cycle_count=0; err_code=0.
  - All outputs 0.
- States: IDLE, ISSUE, WAIT, DONE, ERR. Outputs are Moore-decoded from registered state/regs.
  - layer_start[layer_idx]=1 only in ISSUE.
  - busy=1 in ISSUE/WAIT/DONE.
  - all_done=1 only in DONE.
  - error=1 only in ERR.
- IDLE:
  - run=1 -> ISSUE, layer_idx=0, cycle_count=0.
  - Any layer_done bit in IDLE is ignored.
- ISSUE (exactly 1 cycle):
  - timer cleared.
  - Any layer_done bit =1 -> ERR, err_code=2.
  - Otherwise -> WAIT.
- WAIT: timer increments each cycle. Evaluation priority:
  1. abort.
  2. layer_done has a bit != layer_idx set -> ERR, err_code=2. This applies even if the current bit is also set.
  3. layer_done[layer_idx]=1: if layer_idx==NUM_LAYERS-1 -> DONE; else layer_idx+1 -> ISSUE.
  4. timer==TIMEOUT_CYCLES-1 -> ERR, err_code=1.
  - Done and timeout in the same cycle: done wins.
- DONE (1 cycle) -> IDLE. layer_idx holds the last layer value.
- ERR:
  - Held until clear_err=1 or abort=1.
  - Either exits to IDLE with err_code=0.
  - layer_idx holds the failing layer.
- abort=1 in any non-IDLE state -> IDLE next cycle. No all_done, no error; err_code=0.
- run while busy or in ERR: ignored, no queuing.
- cycle_count:
  - +1 every cycle state is ISSUE/WAIT/DONE; saturates at all-ones.
  - Holds its value in IDLE/ERR until the next accepted run.
- Latency:
  - run high at edge N -> layer_start[0] high in cycle N+1.
  - layer_done[i] at edge M -> layer_start[i+1] in cycle M+1.
  - Last done at M -> all_done in M+1, busy=0 from M+2.
- Reset mid-run: immediate return to the reset state. No pulses are emitted during or after reset.

Test Plan:
Bench settings: NUM_LAYERS=2, TIMEOUT_CYCLES=16.
1. Reset, then run pulse at cycle 5 -> layer_start=01 at cycle 6. layer_done[0] at cycle 10 -> layer_start=10 at 11. layer_done[1] at 20 -> all_done at 21, busy=0 at 22, cycle_count=16.
2. Run, never assert done -> after 16 WAIT cycles: error=1, err_code=1, layer_idx=0. clear_err -> IDLE, error=0. New run accepted.
3. During WAIT on layer 0, assert layer_done=10 -> ERR, err_code=2. Repeat with layer_done=11 -> ERR, err_code=2.
4. Assert layer_done[0] exactly on the 16th WAIT cycle -> no error; layer_start=10 next cycle.
5. abort during WAIT of layer 1 -> IDLE next cycle, no all_done, no error. Further run pulses while busy are ignored; a single all_done occurs per accepted run.
6. Assert rst synchronously mid-WAIT -> all outputs 0 on the next cycle, cycle_count=0. A stale layer_done pulse afterwards has no effect.
